dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory.
- Port 0 serves the core load/store path. Port 1 serves the debug/loader path.
- Accepts one request at a time with round-robin fairness. It drives the memory's address, mem_read, mem_write and write_data inputs for a fixed access window, captures the memory's read data, and returns a one-cycle response to the granted requester.
- Rejects misaligned or out-of-range addresses with an error response and never touches memory for them.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_WORDS, 6: number of valid words. Legal byte addresses are 0x00 to (MEM_WORDS-1)*4.
- WAIT_CYCLES, 1: number of cycles the memory controls are held per access. Range 1–15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request present.
- req0_write  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  byte address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 response strobe.
- rsp0_rdata  out  DATA_W  read data. 0 for writes and errors.
- rsp0_err  out  1  address error.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0, for port 1.
- mem_address  out  ADDR_W  to memory address.
- mem_read  out  1  to memory read enable.
- mem_write  out  1  to memory write enable.
- mem_write_data  out  DATA_W  to memory write data.
- mem_data_out  in  DATA_W  from memory, combinational read data.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
  - On reset: FSM goes to IDLE, last_grant=1 (port 0 wins first), wait counter=0.
  - All outputs are 0 during and after reset until a new request is accepted.
  - Reset mid-access drops the transaction: no response, and mem_read/mem_write deassert immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one reqN_valid is high, that port is selected.
  - If both are high, the port not equal to last_grant is selected.
  - reqN_ready is high combinationally in IDLE for the selected port only. It is never high outside IDLE.
  - On handshake (valid & ready): capture port id, write, addr and wdata; set last_grant=id.
  - Legal address (addr[1:0]==0 and addr < MEM_WORDS*4): go to ACCESS, counter=WAIT_CYCLES-1.
  - Illegal address: go to RESP with err=1 and rdata=0.
- ACCESS:
  - mem_address = captured addr and mem_write_data = captured wdata; both are stable for the whole state.
  - mem_read = ~write and mem_write = write; held for exactly WAIT_CYCLES cycles.
  - Counter decrements each cycle. When counter==0: latch mem_data_out (read) or 0 (write) into rdata, go to RESP.
- RESP:
  - rspN_valid=1 for exactly one cycle on the captured port, together with rdata and err.
  - The other port's response outputs are 0. Go to IDLE.
- Outside ACCESS: mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Latency (handshake in cycle T):
  - Legal request: ACCESS spans T+1..T+WAIT_CYCLES; response in cycle T+WAIT_CYCLES+1.
  - Illegal request: response in cycle T+1.
- Throughput: next handshake is earliest in the cycle after RESP. No pipelining and no response backpressure.
- Requester protocol:
  - Requesters hold valid and all request fields stable until ready.
  - Changes to the request fields while not granted have no effect.
  - A requester that drops valid before grant is not served.
- Arbitration: strict alternation under continuous contention. There is no starvation: a port waits for at most one transaction of the other port.
- rsp*_rdata and rsp*_err are registered. They are 0 whenever the matching rsp*_valid is 0.

Test Plan:
- Reset then port 0 write addr 0x08, data 0xDEADBEEF (WAIT_CYCLES=1) → ready in cycle T; cycle T+1 has mem_write=1, mem_address=0x08, mem_write_data=0xDEADBEEF; cycle T+2 has rsp0_valid=1, rsp0_err=0, rsp0_rdata=0.
- Port 1 read 0x08 after the above, with memory returning 0xDEADBEEF → mem_read=1 for one cycle; rsp1_valid with rsp1_rdata=0xDEADBEEF two cycles after the handshake; port 0 response outputs stay 0.
- Both ports request continuously (reads of 0x00 and 0x04) → grants alternate 0,1,0,1; each response appears on the correct port; no port is granted twice in a row.
- Port 0 read of 0x06 (misaligned) and of 0x18 (out of range with MEM_WORDS=6) → mem_read/mem_write never assert; rsp0_err=1 and rsp0_rdata=0 one cycle after the handshake.
- WAIT_CYCLES=3, port 1 write 0x14 → mem_write high for exactly 3 consecutive cycles; response in cycle T+4.
- reset asserted in the middle of an ACCESS cycle → mem_* outputs drop to 0 asynchronously; no rsp*_valid follows; after release, a port 0/1 tie grants port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-ported data memory.
// Port 0 is the core load/store path, port 1 the debug/loader path. One access at a time:
// legal requests hold the memory controls for WAIT_CYCLES cycles, illegal addresses
// bypass memory, and every request ends with a one-cycle response on its own port.
module dmem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_WORDS   = 6,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ADDR_LIMIT = MEM_WORDS * 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state;
    logic               last_grant;
    logic [CNT_W-1:0]   cnt;
    logic               cap_id;
    logic               cap_write;

    logic               sel_valid;
    logic               sel_id;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_legal;

    // Pick the requester (alternate on contention) and qualify its address
    always_comb begin
        sel_valid  = req0_valid | req1_valid;
        sel_id     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        sel_write  = sel_id ? req1_write : req0_write;
        sel_addr   = sel_id ? req1_addr  : req0_addr;
        sel_wdata  = sel_id ? req1_wdata : req0_wdata;
        sel_legal  = (sel_addr[1:0] == 2'b00) && (sel_addr < ADDR_W'(ADDR_LIMIT));
        req0_ready = (state == IDLE) && req0_valid && !sel_id;
        req1_ready = (state == IDLE) && req1_valid &&  sel_id;
    end

    // Sequencer: grant, hold memory controls for the access window, then respond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            cnt            <= '0;
            cap_id         <= 1'b0;
            cap_write      <= 1'b0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
            rsp0_valid     <= 1'b0;
            rsp0_rdata     <= '0;
            rsp0_err       <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp1_rdata     <= '0;
            rsp1_err       <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        cap_id     <= sel_id;
                        cap_write  <= sel_write;
                        last_grant <= sel_id;
                        if (sel_legal) begin
                            state          <= ACCESS;
                            cnt            <= CNT_W'(WAIT_CYCLES - 1);
                            mem_address    <= sel_addr;
                            mem_write_data <= sel_wdata;
                            mem_read       <= ~sel_write;
                            mem_write      <= sel_write;
                        end else begin
                            state      <= RESP;
                            rsp0_valid <= ~sel_id;
                            rsp0_err   <= ~sel_id;
                            rsp1_valid <= sel_id;
                            rsp1_err   <= sel_id;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state          <= RESP;
                        mem_address    <= '0;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_write_data <= '0;
                        if (cap_id) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= cap_write ? '0 : mem_data_out;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= cap_write ? '0 : mem_data_out;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
